data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-side memory responder for the single-cycle CPU: it answers the CPU's `mem_read`/`mem_write` requests with a word-addressed RAM plus a small memory-mapped I/O region. The MMIO region holds a free-running cycle counter, a byte output FIFO drained by an external consumer over a valid/ready handshake, and a dropped-byte counter. Reads are combinational, so the CPU's single-cycle load path closes within one cycle. All writes commit on the rising clock edge.

## Interface

Parameters:
- `ADDR_BITS`, 8: RAM depth is 2^ADDR_BITS 32-bit words.
- `FIFO_DEPTH`, 4: output FIFO entries. Power of two, 2..8.

Ports:
- `clk`  in  1  Clock. One clock domain; all state updates on the rising edge.
- `rst`  in  1  Reset, asynchronous, active-low.
- `data_addr`  in  32  Byte address from the CPU. Bits [1:0] are ignored.
- `data_in`  in  32  Write data from the CPU (CPU store data).
- `data_out`  out  32  Read data to the CPU (CPU load data).
- `mem_read`  in  1  Read request.
- `mem_write`  in  1  Write request. Commits at the clock edge.
- `out_data`  out  8  FIFO head byte.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  Consumer accepts the head byte at the edge when `out_valid` is high.

## Operation

Address decode:
- When `data_addr[31]` is 0, the access goes to RAM word `data_addr[ADDR_BITS+1:2]`. Higher address bits are ignored, so the RAM aliases.
- `0x8000_0000` CYCLE: read returns the counter; write loads it.
- `0x8000_0004` TXPUSH: write pushes `data_in[7:0]`; read returns 0.
- `0x8000_0008` STATUS, read-only:
  - bit0 = full
  - bit1 = empty
  - bits[7:4] = FIFO count
  - other bits 0
- `0x8000_000C` DROPS: read returns the dropped-push count; a write clears it to 0.
- Any other address with bit31 set: read returns 0, write is ignored.

Read path:
- `data_out` is combinational: the selected value when `mem_read` is 1, otherwise 0.
- If `mem_read` and `mem_write` are both high, the read returns the pre-write value.

RAM:
- Not reset; contents are undefined until written.
- A write replaces the full 32-bit word.

Cycle counter:
- 32-bit, increments every cycle while out of reset and wraps from 0xFFFF_FFFF to 0.
- A CYCLE write takes priority over the increment: the register holds `data_in` after the edge and resumes incrementing on the following edge.

FIFO:
- `out_valid` = (count != 0). `out_data` = head entry, 0 when empty.
- Pop occurs at an edge when `out_valid` and `out_ready` are both 1.
- A TXPUSH is accepted if count < FIFO_DEPTH, or if a pop occurs at the same edge. Otherwise the byte is dropped and DROPS increments, saturating at 0xFFFF_FFFF.
- Simultaneous accepted push and pop leaves count unchanged.
- Read and write pointers wrap modulo FIFO_DEPTH.

Reset (asserted asynchronously):
- CYCLE, DROPS, FIFO count and FIFO pointers all go to 0.
- `out_valid` = 0 and `out_data` = 0 immediately.
- `data_out` follows its combinational rule.
- Any write in flight at reset assertion is discarded.
- RAM contents are unaffected.

## Timing

- Read latency: 0 cycles, same-cycle combinational from `data_addr` and `mem_read`.
- Write latency: visible to reads in the cycle after the edge.
- After a push into an empty FIFO, `out_valid` rises in the next cycle.
- After the pop of the last entry, `out_valid` falls in the next cycle.
- STATUS, CYCLE and DROPS reads reflect register state before the current edge.
- Reset release: on the first rising edge with `rst` high, CYCLE becomes 1.

## Test plan

- Reset: hold `rst` low mid-run with the FIFO holding 3 bytes -> `out_valid`=0 and `out_data`=0 immediately. After release, STATUS reads 0x2 and DROPS reads 0. The CYCLE read after 5 edges returns 5.
- RAM: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> 0xDEADBEEF. Reading 0x0000_0410 (alias, ADDR_BITS=8) -> 0xDEADBEEF. With `mem_read`=0, `data_out`=0.
- Counter: write 0xFFFF_FFFE to CYCLE -> reads in the next two cycles return 0xFFFF_FFFE, then 0xFFFF_FFFF; the cycle after returns 0.
- FIFO overflow: with `out_ready`=0, push 0x41..0x46 -> STATUS reads 0x41 (count 4, full), DROPS reads 2, `out_data`=0x41. Raising `out_ready` drains 0x41, 0x42, 0x43, 0x44 in order, then `out_valid`=0.
- Full push+pop: FIFO full with head 0x41 and `out_ready`=1, push 0x55 -> accepted; DROPS unchanged, count stays 4, new head 0x42, tail 0x55.
- Simultaneous read+write: `mem_read`=`mem_write`=1 at RAM word 0x20 holding 7, writing 9 -> `data_out`=7 that cycle; the next read returns 9.

Source files
------------

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Data-side memory responder for the single-cycle CPU. Serves combinational
// loads and edge-committed stores against a word-addressed RAM plus a small
// memory-mapped I/O block:
//   0x8000_0000 CYCLE  : free-running cycle counter (read, write loads)
//   0x8000_0004 TXPUSH : write pushes data_in[7:0] into the output FIFO
//   0x8000_0008 STATUS : {count[7:4], empty[1], full[0]} (read-only)
//   0x8000_000C DROPS  : dropped-push counter (read, write clears)
// Any other address with bit31 set reads 0 and ignores writes.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset
//   data_addr  CPU byte address (bits [1:0] ignored)
//   data_in    CPU store data
//   data_out   CPU load data (combinational, 0 when mem_read is low)
//   mem_read   read request
//   mem_write  write request, commits at the clock edge
//   out_data   FIFO head byte (0 when empty)
//   out_valid  FIFO non-empty
//   out_ready  consumer accepts the head byte at the edge
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int ADDR_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_WORDS = 1 << ADDR_BITS;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  // MMIO register word addresses (byte address >> 2)
  localparam logic [29:0] WA_CYCLE  = 30'h2000_0000;
  localparam logic [29:0] WA_TXPUSH = 30'h2000_0001;
  localparam logic [29:0] WA_STATUS = 30'h2000_0002;
  localparam logic [29:0] WA_DROPS  = 30'h2000_0003;

  // Saturating increment for the dropped-push counter.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // STATUS word assembly.
  function automatic logic [31:0] status_word(input logic [CNT_W-1:0] cnt);
    logic [31:0] s;
    s      = '0;
    s[0]   = (cnt == DEPTH_C);
    s[1]   = (cnt == '0);
    s[7:4] = 4'(cnt);
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [29:0]          word_addr;
  logic                 is_mmio;
  logic [ADDR_BITS-1:0] ram_idx;
  logic                 sel_cycle;
  logic                 sel_txpush;
  logic                 sel_status;
  logic                 sel_drops;
  logic                 unused_addr_lsbs;

  assign word_addr        = data_addr[31:2];
  assign is_mmio          = data_addr[31];
  assign ram_idx          = data_addr[ADDR_BITS+1:2];
  assign sel_cycle        = (word_addr == WA_CYCLE);
  assign sel_txpush       = (word_addr == WA_TXPUSH);
  assign sel_status       = (word_addr == WA_STATUS);
  assign sel_drops        = (word_addr == WA_DROPS);
  assign unused_addr_lsbs = ^data_addr[1:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0]      ram [RAM_WORDS];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [31:0]      cycle_q;
  logic [31:0]      drops_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;

  // ---------------------------------------------------------------------------
  // Write-side control
  // ---------------------------------------------------------------------------
  logic ram_we;
  logic cycle_we;
  logic drops_clr;
  logic push_req;
  logic pop;
  logic push_ok;
  logic drop;

  // rst is folded into the data-array enables so a store in flight when
  // reset asserts never lands in RAM or FIFO storage.
  assign ram_we    = rst & mem_write & ~is_mmio;
  assign cycle_we  = mem_write & sel_cycle;
  assign drops_clr = mem_write & sel_drops;
  assign push_req  = mem_write & sel_txpush;

  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & out_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok   = push_req & ((cnt_q < DEPTH_C) | pop);
  assign drop      = push_req & ~push_ok;

  assign out_data  = out_valid ? fifo_mem[rd_ptr_q] : 8'h00;

  // ---------------------------------------------------------------------------
  // Data arrays (not reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      fifo_mem[wr_ptr_q] <= data_in[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_q <= '0;
    end else if (cycle_we) begin
      cycle_q <= data_in;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drops_q <= '0;
    end else if (drops_clr) begin
      drops_q <= '0;
    end else if (drop) begin
      drops_q <= sat_inc32(drops_q);
    end
  end

  // Pointers are PTR_W bits wide, so natural overflow wraps them modulo
  // FIFO_DEPTH (a power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Combinational read path (always the pre-edge state)
  // ---------------------------------------------------------------------------
  always_comb begin
    data_out = '0;
    if (mem_read) begin
      if (!is_mmio) begin
        data_out = ram[ram_idx];
      end else if (sel_cycle) begin
        data_out = cycle_q;
      end else if (sel_status) begin
        data_out = status_word(cnt_q);
      end else if (sel_drops) begin
        data_out = drops_q;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder. Load results are queued as
// expectations when a read is driven and compared once data_out settles.
// Pushed bytes are modelled in a byte queue; a negedge monitor compares the
// FIFO head/valid against the model and retires entries on handshakes.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_TXPUSH = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam logic [31:0] A_DROPS  = 32'h8000_000C;
  localparam logic [31:0] A_UNMAP  = 32'h8000_0010;
  localparam int          DEPTH    = 4;

  logic        clk;
  logic        rst;
  logic [31:0] data_addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  int          n_cmp;
  int          n_bad;
  logic        mon_en;
  logic [7:0]  fq[$];
  logic [31:0] rd_q[$];
  logic [31:0] exp_drops;

  data_mem_responder #(
    .ADDR_BITS (8),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_addr(data_addr),
    .data_in  (data_in),
    .data_out (data_out),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle store; FIFO pushes update the model once the edge commits.
  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    logic accept;
    accept    = (fq.size() < DEPTH) || (out_ready && fq.size() > 0);
    data_addr = addr;
    data_in   = d;
    mem_read  = 1'b0;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    if (addr == A_TXPUSH) begin
      if (accept) fq.push_back(d[7:0]);
      else if (exp_drops != 32'hFFFF_FFFF) exp_drops++;
    end
    if (addr == A_DROPS) exp_drops = 0;
  endtask

  // One-cycle load checked against the queued expectation.
  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    rd_q.push_back(exp);
    data_addr = addr;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    #1;
    check(tag, data_out, rd_q.pop_front());
    mem_read = 1'b0;
    tick();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (fq.size() == 0) break;
      tick();
    end
    check({tag, "_model_empty"}, 32'(fq.size()), 32'd0);
    check({tag, "_valid_low"}, 32'(out_valid), 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (fq.size() == 0) begin
        check("out_valid_empty", 32'(out_valid), 32'd0);
        check("out_data_empty", 32'(out_data), 32'd0);
      end else begin
        check("out_valid_busy", 32'(out_valid), 32'd1);
        check("out_head", 32'(out_data), 32'(fq[0]));
        if (out_ready) void'(fq.pop_front());
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    mon_en    = 1'b0;
    exp_drops = 0;
    rst       = 1'b0;
    data_addr = '0;
    data_in   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b1;
    mon_en = 1'b1;

    rd("status_after_por", A_STATUS, 32'h2);

    // Mid-run reset with three bytes queued
    wr(A_TXPUSH, 32'h31);
    wr(A_TXPUSH, 32'h32);
    wr(A_TXPUSH, 32'h33);
    rd("status_three", A_STATUS, 32'h30);
    rst = 1'b0;
    fq.delete();
    exp_drops = 0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    rd("rst_status", A_STATUS, 32'h2);
    rd("rst_drops", A_DROPS, 32'd0);
    tick();
    tick();
    tick();
    rd("rst_cycle5", A_CYCLE, 32'd5);

    // RAM write, read, alias, read gating
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_read", 32'h0000_0010, 32'hDEAD_BEEF);
    rd("ram_alias", 32'h0000_0410, 32'hDEAD_BEEF);
    data_addr = 32'h0000_0010;
    mem_read  = 1'b0;
    #1;
    check("ram_noread", data_out, 32'd0);
    tick();
    wr(32'h0000_0014, 32'h1234_5678);
    rd("ram_neighbor", 32'h0000_0014, 32'h1234_5678);
    rd("ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);

    // Simultaneous read + write returns pre-write data
    wr(32'h0000_0080, 32'd7);
    data_addr = 32'h0000_0080;
    data_in   = 32'd9;
    mem_read  = 1'b1;
    mem_write = 1'b1;
    #1;
    check("rw_old", data_out, 32'd7);
    tick();
    mem_write = 1'b0;
    mem_read  = 1'b0;
    rd("rw_new", 32'h0000_0080, 32'd9);

    // Counter load and wrap
    wr(A_CYCLE, 32'hFFFF_FFFE);
    rd("cyc_load", A_CYCLE, 32'hFFFF_FFFE);
    rd("cyc_max", A_CYCLE, 32'hFFFF_FFFF);
    rd("cyc_wrap", A_CYCLE, 32'h0000_0000);

    // Unmapped MMIO and TXPUSH read as zero
    wr(A_UNMAP, 32'hAAAA_5555);
    rd("unmapped", A_UNMAP, 32'd0);
    rd("txpush_read", A_TXPUSH, 32'd0);

    // Overflow: six pushes into a depth-4 FIFO
    out_ready = 1'b0;
    for (int b = 'h41; b <= 'h46; b++) wr(A_TXPUSH, 32'(b));
    rd("ovf_status", A_STATUS, 32'h41);
    rd("ovf_drops", A_DROPS, exp_drops);
    check("ovf_drops_model", exp_drops, 32'd2);
    check("ovf_head", 32'(out_data), 32'h41);
    out_ready = 1'b1;
    drain("ovf_drain");
    out_ready = 1'b0;

    // Full FIFO takes a push when the head pops on the same edge
    for (int b = 'h41; b <= 'h44; b++) wr(A_TXPUSH, 32'(b));
    out_ready = 1'b1;
    wr(A_TXPUSH, 32'h55);
    out_ready = 1'b0;
    rd("pp_status", A_STATUS, 32'h41);
    rd("pp_drops", A_DROPS, 32'd2);
    check("pp_head", 32'(out_data), 32'h42);
    out_ready = 1'b1;
    drain("pp_drain");
    out_ready = 1'b0;

    // DROPS write clears
    wr(A_DROPS, 32'h1234);
    rd("drops_clr", A_DROPS, 32'd0);
    rd("status_end", A_STATUS, 32'h2);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
